// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory access sizes and FSM states.
package lsu_pkg;

   localparam int DATA_WIDTH = 32;

   // 2'b11 is left unencoded and is treated as an invalid access size
   typedef enum logic [1:0] {
      BYTE      = 2'b00,
      HALF_WORD = 2'b01,
      WORD      = 2'b10
   } ram_size_e;

   typedef enum logic [1:0] {
      IDLE,
      BUS_REQ,
      BUS_WAIT,
      RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response channel from execute and word-aligned req/gnt/rvalid data RAM bus.
interface lsu_req_if
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [1:0]            req_size_i;
   logic                  req_unsigned_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_fault_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_fault_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_fault_o
   );
endinterface

interface lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req_o;
   logic                  mem_gnt_i;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [3:0]            mem_be_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_rvalid_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane placement for stores, load extraction/extension and alignment check.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]            offset,
   input  logic [1:0]            size,
   input  logic                  zero_ext,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [3:0]            be,
   output logic [DATA_WIDTH-1:0] lane_wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  misaligned
);
   logic [DATA_WIDTH-1:0] shifted;

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      be         = 4'b0000;
      lane_wdata = '0;
      load_data  = '0;
      misaligned = 1'b0;
      shifted    = rdata >> {offset, 3'b000};
      case (size)
         BYTE: begin
            be         = 4'b0001 << offset;
            lane_wdata = {4{wdata[7:0]}};
            load_data  = {{24{shifted[7] & ~zero_ext}}, shifted[7:0]};
         end
         HALF_WORD: begin
            be         = 4'b0011 << offset;
            lane_wdata = {2{wdata[15:0]}};
            load_data  = {{16{shifted[15] & ~zero_ext}}, shifted[15:0]};
            misaligned = offset[0];
         end
         WORD: begin
            be         = 4'b1111;
            lane_wdata = wdata;
            load_data  = shifted;
            misaligned = (offset != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access per handshake onto a req/gnt/rvalid data RAM bus,
// returning the extended load result or a fault (misaligned, invalid size, timeout).
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic      clk,
   input  logic      rst,
   lsu_req_if.slave  req,
   lsu_mem_if.master mem
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_e            state_q, state_d;
   logic                  we_q, uns_q, fault_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  is_idle, accept, timed_out, to_fault;
   logic [1:0]            align_offset, align_size;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] lane_wdata, load_data;
   logic                  misaligned;

   assign is_idle = (state_q == IDLE);

   // In IDLE the aligner checks the incoming request; afterwards it works on the captured one.
   assign align_offset = is_idle ? req.req_addr_i[1:0] : addr_q[1:0];
   assign align_size   = is_idle ? req.req_size_i      : size_q;

   lsu_align u_align (
      .offset     (align_offset),
      .size       (align_size),
      .zero_ext   (uns_q),
      .wdata      (wdata_q),
      .rdata      (mem.mem_rdata_i),
      .be         (be),
      .lane_wdata (lane_wdata),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      to_fault = 1'b0;
      case (state_q)
         IDLE: begin
            if (req.req_valid_i) begin
               accept  = 1'b1;
               state_d = misaligned ? RESP : BUS_REQ;
            end
         end
         BUS_REQ: begin
            if (timed_out) begin
               to_fault = 1'b1;
               state_d  = RESP;
            end else if (mem.mem_gnt_i) begin
               state_d = BUS_WAIT;
            end
         end
         BUS_WAIT: begin
            // A response arriving on the last allowed cycle still wins over the timeout
            if (mem.mem_rvalid_i) begin
               state_d = RESP;
            end else if (timed_out) begin
               to_fault = 1'b1;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         fault_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            we_q    <= req.req_we_i;
            uns_q   <= req.req_unsigned_i;
            size_q  <= req.req_size_i;
            addr_q  <= req.req_addr_i;
            wdata_q <= req.req_wdata_i;
            fault_q <= misaligned;
            rdata_q <= '0;
         end else if (state_q == BUS_WAIT && mem.mem_rvalid_i) begin
            rdata_q <= we_q ? '0 : load_data;
         end else if (to_fault) begin
            fault_q <= 1'b1;
         end

         if (state_q == BUS_REQ || state_q == BUS_WAIT) cnt_q <= cnt_q + 1'b1;
         else                                           cnt_q <= '0;
      end
   end

   assign req.req_ready_o = is_idle;
   assign req.rsp_valid_o = (state_q == RESP);
   assign req.rsp_rdata_o = rdata_q;
   assign req.rsp_fault_o = fault_q;

   assign mem.mem_req_o   = (state_q == BUS_REQ);
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem.mem_be_o    = (state_q == BUS_REQ) ? be : 4'b0000;
   assign mem.mem_wdata_o = lane_wdata;

endmodule
